ssd_share_arbiter: RTL and testbench

Arbitrates ownership of the 8-digit seven-segment display between two requesters, such as a switch-readout path and a status/message path. It selects one requester's 32-bit hex word, eight nibbles with nibble 0 as the rightmost digit, and drives it to the seven_segment scanner's data input. Grants are round-robin, with a minimum-tenure timer so the display does not flicker between owners. When no one is requesting, the display is blanked to a default word.

---
 rtl/ssd_share_arbiter.sv | 122 ++++++++++++
 tb/tb_ssd_share_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_share_arbiter.sv
// Round-robin owner arbitration of the 8-digit seven-segment display between two requesters,
// with a minimum-tenure timer to prevent flicker and a default word when idle.
module ssd_share_arbiter #(
    parameter int unsigned HOLD_CYCLES  = 100_000_000,
    parameter logic [31:0] DEFAULT_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    output logic [1:0]  gnt,
    output logic [31:0] disp_word,
    output logic        owner_chg
);

    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             pri;
    logic             pri_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       gnt_nxt;
    logic [31:0]      disp_nxt;
    logic             chg_nxt;
    logic             tenure_done;

    // State, priority pointer, tenure counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pri       <= 1'b0;
            cnt       <= '0;
            gnt       <= 2'b00;
            disp_word <= DEFAULT_WORD;
            owner_chg <= 1'b0;
        end else begin
            state     <= state_nxt;
            pri       <= pri_nxt;
            cnt       <= cnt_nxt;
            gnt       <= gnt_nxt;
            disp_word <= disp_nxt;
            owner_chg <= chg_nxt;
        end
    end

    // Next-state decision and next values of every register
    always_comb begin
        state_nxt   = state;
        pri_nxt     = pri;
        cnt_nxt     = '0;
        gnt_nxt     = 2'b00;
        disp_nxt    = DEFAULT_WORD;
        chg_nxt     = 1'b0;
        tenure_done = (cnt >= CNT_MAX);

        case (state)
            IDLE: begin
                case (req)
                    2'b01:   state_nxt = OWN0;
                    2'b10:   state_nxt = OWN1;
                    2'b11:   state_nxt = pri ? OWN1 : OWN0;
                    default: state_nxt = IDLE;
                endcase
            end
            OWN0: begin
                if (!req[0]) begin
                    state_nxt = req[1] ? OWN1 : IDLE;
                end else if (tenure_done && req[1]) begin
                    state_nxt = OWN1;
                end
            end
            OWN1: begin
                if (!req[1]) begin
                    state_nxt = req[0] ? OWN0 : IDLE;
                end else if (tenure_done && req[0]) begin
                    state_nxt = OWN0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        case (state_nxt)
            OWN0: begin
                gnt_nxt  = 2'b01;
                disp_nxt = data0;
            end
            OWN1: begin
                gnt_nxt  = 2'b10;
                disp_nxt = data1;
            end
            default: begin
                gnt_nxt  = 2'b00;
                disp_nxt = DEFAULT_WORD;
            end
        endcase

        // A fresh grant restarts tenure and hands priority to the other requester
        if (state_nxt != IDLE) begin
            if (state_nxt != state) begin
                cnt_nxt = '0;
                pri_nxt = (state_nxt == OWN0);
            end else if (!tenure_done) begin
                cnt_nxt = cnt + CNT_W'(1);
            end else begin
                cnt_nxt = cnt;
            end
        end

        chg_nxt = (gnt_nxt != gnt);
    end

endmodule

// File: tb/tb_ssd_share_arbiter.sv
// Directed and random scoreboard bench for ssd_share_arbiter (HOLD_CYCLES=4, DEFAULT_WORD=FFFF_FFFF).
module tb_ssd_share_arbiter;

    localparam int unsigned HOLD = 4;
    localparam logic [31:0] DEF  = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [1:0]  gnt;
    logic [31:0] disp_word;
    logic        owner_chg;

    ssd_share_arbiter #(.HOLD_CYCLES(HOLD), .DEFAULT_WORD(DEF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .gnt       (gnt),
        .disp_word (disp_word),
        .owner_chg (owner_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  g;
        logic [31:0] d;
        logic        c;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Reference model: owner -1 = idle, 0/1 = requester; tenure in edges since grant
    int          m_own;
    int          m_pri;
    int          m_ten;
    logic [1:0]  m_gnt;

    // Observed-history trackers for the stress invariants
    logic [1:0]  prev_gnt;
    logic [1:0]  prev_req;
    int          held;

    task automatic model_reset();
        m_own = -1;
        m_pri = 0;
        m_ten = 0;
        m_gnt = 2'b00;
        sb.delete();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Predict the result of the coming edge from current inputs and push it
    task automatic model_push(input string tag);
        int   nown;
        int   oth;
        exp_t e;
        if (m_own < 0) begin
            if (req == 2'b01)      nown = 0;
            else if (req == 2'b10) nown = 1;
            else if (req == 2'b11) nown = m_pri;
            else                   nown = -1;
        end else begin
            oth = 1 - m_own;
            if (!req[m_own])                              nown = req[oth] ? oth : -1;
            else if (m_ten >= int'(HOLD) - 1 && req[oth]) nown = oth;
            else                                          nown = m_own;
        end
        if (nown >= 0 && nown != m_own) begin
            m_ten = 0;
            m_pri = 1 - nown;
        end else if (nown >= 0) begin
            if (m_ten < int'(HOLD) - 1) m_ten++;
        end else begin
            m_ten = 0;
        end
        e.g   = (nown < 0) ? 2'b00 : ((nown == 0) ? 2'b01 : 2'b10);
        e.d   = (nown < 0) ? DEF : ((nown == 0) ? data0 : data1);
        e.c   = (e.g != m_gnt);
        e.tag = tag;
        m_gnt = e.g;
        m_own = nown;
        sb.push_back(e);
    endtask

    task automatic sb_pop();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_gnt"}, 32'(gnt), 32'(e.g));
            chk({e.tag, "_disp"}, disp_word, e.d);
            chk({e.tag, "_chg"}, 32'(owner_chg), 32'(e.c));
        end
    endtask

    // Drive inputs, predict, take one edge, then compare just after it
    task automatic step(input logic [1:0] r, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
        req   = r;
        data0 = a;
        data1 = b;
        model_push(tag);
        @(posedge clk);
        #1;
        sb_pop();
    endtask

    task automatic expect_now(input string tag, input logic [1:0] g, input logic [31:0] d,
                              input logic c);
        chk({tag, "_gnt"}, 32'(gnt), 32'(g));
        chk({tag, "_disp"}, disp_word, d);
        chk({tag, "_chg"}, 32'(owner_chg), 32'(c));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect_now("rst_hold", 2'b00, DEF, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 2'b00;
        data0 = 32'h0;
        data1 = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        expect_now("por", 2'b00, DEF, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        step(2'b00, 32'h0, 32'h0, "idle");
        expect_now("idle_c", 2'b00, DEF, 1'b0);

        // Single requester, live data tracking, release
        step(2'b01, 32'h0001_2345, 32'h5555_5555, "single_gnt");
        expect_now("single_gnt_c", 2'b01, 32'h0001_2345, 1'b1);
        step(2'b01, 32'h0000_00AB, 32'h5555_5555, "single_data");
        expect_now("single_data_c", 2'b01, 32'h0000_00AB, 1'b0);
        step(2'b00, 32'h0000_00AB, 32'h5555_5555, "single_drop");
        expect_now("single_drop_c", 2'b00, DEF, 1'b1);

        // Simultaneous requests from reset and round-robin pointer
        pulse_reset();
        step(2'b11, 32'hAAAA_0000, 32'hBBBB_1111, "both");
        expect_now("both_c", 2'b01, 32'hAAAA_0000, 1'b1);
        step(2'b10, 32'hAAAA_0000, 32'hBBBB_1111, "handoff");
        expect_now("handoff_c", 2'b10, 32'hBBBB_1111, 1'b1);
        step(2'b00, 32'hAAAA_0000, 32'hBBBB_1111, "both_drop");
        step(2'b11, 32'hAAAA_0000, 32'hBBBB_1111, "both_again");
        expect_now("both_again_c", 2'b01, 32'hAAAA_0000, 1'b1);
        step(2'b00, 32'h0, 32'h0, "both_end");

        // Preemption exactly HOLD edges after the grant
        step(2'b01, 32'h1111_0000, 32'h2222_0000, "pre_gnt");
        for (int i = 1; i < int'(HOLD); i++) begin
            step(2'b11, 32'h1111_0000, 32'h2222_0000, "pre_wait");
            expect_now("pre_wait_c", 2'b01, 32'h1111_0000, 1'b0);
        end
        step(2'b11, 32'h1111_0000, 32'h2222_0000, "pre_switch");
        expect_now("pre_switch_c", 2'b10, 32'h2222_0000, 1'b1);
        step(2'b00, 32'h0, 32'h0, "pre_end");

        // Long tenure with a quiet peer, then immediate switch
        step(2'b01, 32'h3333_0000, 32'h4444_0000, "polite_gnt");
        for (int i = 0; i < 10; i++) step(2'b01, 32'h3333_0000, 32'h4444_0000, "polite_hold");
        expect_now("polite_hold_c", 2'b01, 32'h3333_0000, 1'b0);
        step(2'b11, 32'h3333_0000, 32'h4444_0000, "polite_switch");
        expect_now("polite_switch_c", 2'b10, 32'h4444_0000, 1'b1);
        step(2'b00, 32'h0, 32'h0, "polite_end");

        // Asynchronous reset in the middle of an OWN1 tenure
        step(2'b10, 32'h0, 32'h7777_7777, "mid_gnt");
        step(2'b10, 32'h0, 32'h7777_7777, "mid_hold");
        rst_n = 1'b0;
        #1;
        expect_now("async_rst", 2'b00, DEF, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(2'b00, 32'h0, 32'h0, "post_rst");

        // Random stress with invariant checks on observed outputs
        prev_gnt = gnt;
        held     = 0;
        for (int i = 0; i < 10000; i++) begin
            prev_req = $urandom_range(0, 9) < 7 ? req : 2'($urandom_range(0, 3));
            step(prev_req, $urandom, $urandom, "rand");
            chk("rand_onehot", 32'(gnt == 2'b11), 32'd0);
            chk("rand_chg_vs_gnt", 32'(owner_chg), 32'(gnt != prev_gnt));
            if (prev_gnt != 2'b00 && gnt != 2'b00 && gnt != prev_gnt && (prev_req & prev_gnt) != 2'b00)
                chk("rand_min_tenure", 32'(held + 1 >= int'(HOLD)), 32'd1);
            held     = (gnt == prev_gnt && gnt != 2'b00) ? held + 1 : 0;
            prev_gnt = gnt;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
